// File: rtl/adder_result_buffer.sv
// adder_result_buffer
// Downstream companion of the pipelined 4-bit ripple adder. It follows each
// accepted operand issue through the adder's fixed latency and captures the
// matching {cout, S} into a small FIFO. The result is presented to the
// consumer over a valid/ready handshake. A credit counter throttles issue so
// that a capture always has room. A saturating counter tallies carry-outs.
//
// Parameters:
//   LATENCY  cycles from accepted issue to valid S/cout (1..16)
//   DEPTH    FIFO entries, power of two (2..16)
//   CNT_W    width of carry_count
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   issue_valid  upstream drives operands into the adder this cycle
//   issue_ready  credit available; issue accepted on issue_valid && issue_ready
//   S, cout      adder sum / carry outputs
//   m_data       {cout, S} at FIFO head
//   m_valid      FIFO non-empty
//   m_ready      consumer takes m_data this cycle
//   carry_count  captured results with cout=1, saturating
//   issue_err    sticky: issue_valid seen while issue_ready=0
//   full, empty  FIFO occupancy flags
module adder_result_buffer #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       S,
  input  logic             cout,
  output logic [4:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] carry_count,
  output logic             issue_err,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [LATENCY-1:0] vld_pipe;
  logic [4:0]         mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [CW-1:0]      used;
  logic               accept;
  logic               push;
  logic               pop;

  assign accept      = issue_valid && issue_ready;
  assign push        = vld_pipe[LATENCY-1];
  assign pop         = m_valid && m_ready;
  assign issue_ready = (used < CW'(DEPTH));
  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign m_valid     = !empty;
  assign m_data      = mem[rd_ptr];

  // Shadow of the adder pipeline: the tail bit says S/cout belong to an
  // accepted issue. Rejected issues never enter, so their results are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  // Capture is unconditional; credits already reserved the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {cout, S};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Credits cover in-flight results plus stored entries, so used never
  // exceeds DEPTH and the FIFO cannot overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_count <= '0;
    end else if (push && cout && (carry_count != '1)) begin
      carry_count <= carry_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_err <= 1'b0;
    end else if (issue_valid && !issue_ready) begin
      issue_err <= 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == CW'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && (count == '0)));

  a_credit_balance: assert property (@(posedge clk) disable iff (rst)
    (int'(used) == ($countones(vld_pipe) + int'(count))));

endmodule
